bsg_tag_boot_sequencer: RTL



---
 rtl/bsg_tag_boot_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bsg_tag_boot_sequencer.sv
// bsg_tag boot sequencer: serializes parallel tag commands into the
// clk/en/data stream of the bsg_tag master, with a zero preamble after
// reset and a zero gap after every packet.
// Optional statistics outputs are enabled by BSG_TAG_BOOT_SEQUENCER_STATS_EN.
module bsg_tag_boot_sequencer #(
  parameter int els_p       = 32,
  parameter int lg_width_p  = 4,
  parameter int clk_div_p   = 4,
  parameter int gap_bits_p  = 4,
  parameter int init_bits_p = 64,
  localparam int id_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int pw_lp       = (1 << lg_width_p) - 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   cmd_v_i,
  output logic                   cmd_ready_o,
  input  logic [id_width_lp-1:0] cmd_id_i,
  input  logic                   cmd_dnr_i,
  input  logic [lg_width_p-1:0]  cmd_len_i,
  input  logic [pw_lp-1:0]       cmd_payload_i,
  output logic                   tag_clk_o,
  output logic                   tag_en_o,
  output logic                   tag_data_o,
  output logic                   busy_o,
`ifdef BSG_TAG_BOOT_SEQUENCER_STATS_EN
  output logic [15:0]            pkt_count_o,
  output logic [id_width_lp-1:0] last_id_o,
`endif
  output logic                   done_o
);

  localparam int DIV_W    = $clog2(2 * clk_div_p);
  localparam int DIV_LAST = 2 * clk_div_p - 1;
  localparam int M1       = (init_bits_p > gap_bits_p) ? init_bits_p : gap_bits_p;
  localparam int M2       = (M1 > pw_lp) ? M1 : pw_lp;
  localparam int M3       = (M2 > id_width_lp) ? M2 : id_width_lp;
  localparam int CNT_W    = $clog2(M3 + 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_PEND, S_START, S_ID, S_DNR, S_LEN, S_PAYLOAD, S_GAP
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_q, bit_d;
  logic [DIV_W-1:0]       div_q;
  logic                   en_q;
  logic                   slot_end;
  logic                   hs;

  logic [id_width_lp-1:0] id_q;
  logic                   dnr_q;
  logic [lg_width_p-1:0]  len_q;
  logic [pw_lp-1:0]       payload_q;

  logic                   id_bit, len_bit, pay_bit;

  // Last cycle of a bit slot: every field transition happens on this edge.
  assign slot_end  = (div_q == DIV_W'(DIV_LAST));
  assign hs        = cmd_v_i && (state_q == S_IDLE);
  assign tag_clk_o = (div_q >= DIV_W'(clk_div_p));
  assign tag_en_o  = en_q;

  assign id_bit  = 1'(id_q >> bit_q);
  assign len_bit = 1'(len_q >> bit_q);
  assign pay_bit = 1'(payload_q >> bit_q);

  // State, bit counter and free-running tag-clock divider.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_INIT;
      bit_q   <= '0;
      div_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      div_q   <= slot_end ? '0 : div_q + 1'b1;
      en_q    <= 1'b1;
    end
  end

  // Command capture; discarded implicitly by reset returning the FSM to INIT.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      id_q      <= cmd_id_i;
      dnr_q     <= cmd_dnr_i;
      len_q     <= cmd_len_i;
      payload_q <= cmd_payload_i;
    end
  end

  // Next-state: advance one field bit per slot boundary.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    case (state_q)
      S_INIT: if (slot_end) begin
        if (bit_q == CNT_W'(init_bits_p - 1)) begin
          state_d = S_IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_IDLE: begin
        bit_d = '0;
        // A command taken on the slot's last cycle starts at the next boundary.
        if (cmd_v_i) state_d = slot_end ? S_START : S_PEND;
      end
      S_PEND: if (slot_end) state_d = S_START;
      S_START: if (slot_end) begin
        state_d = S_ID;
        bit_d   = '0;
      end
      S_ID: if (slot_end) begin
        if (bit_q == CNT_W'(id_width_lp - 1)) begin
          state_d = S_DNR;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_DNR: if (slot_end) begin
        state_d = S_LEN;
        bit_d   = '0;
      end
      S_LEN: if (slot_end) begin
        if (bit_q == CNT_W'(lg_width_p - 1)) begin
          state_d = (len_q == '0) ? S_GAP : S_PAYLOAD;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_PAYLOAD: if (slot_end) begin
        if ((bit_q + 1'b1) == CNT_W'(len_q)) begin
          state_d = S_GAP;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_GAP: if (slot_end) begin
        if (bit_q == CNT_W'(gap_bits_p - 1)) begin
          state_d = S_IDLE;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state; data only moves when the state/bit counter do.
  always_comb begin
    cmd_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q == S_PEND) || (state_q == S_START) || (state_q == S_ID) ||
                  (state_q == S_DNR) || (state_q == S_LEN) || (state_q == S_PAYLOAD) ||
                  (state_q == S_GAP);
    done_o      = (state_q == S_GAP) && slot_end && (bit_q == CNT_W'(gap_bits_p - 1));
    tag_data_o  = 1'b0;
    case (state_q)
      S_START:   tag_data_o = 1'b1;
      S_ID:      tag_data_o = id_bit;
      S_DNR:     tag_data_o = dnr_q;
      S_LEN:     tag_data_o = len_bit;
      S_PAYLOAD: tag_data_o = pay_bit;
      default:   tag_data_o = 1'b0;
    endcase
  end

`ifdef BSG_TAG_BOOT_SEQUENCER_STATS_EN
  logic [15:0]            pkt_count_q;
  logic [id_width_lp-1:0] last_id_q;

  // Completed-packet counter (wraps) and id of the most recent packet.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_count_q <= '0;
      last_id_q   <= '0;
    end else if (done_o) begin
      pkt_count_q <= pkt_count_q + 16'd1;
      last_id_q   <= id_q;
    end
  end

  assign pkt_count_o = pkt_count_q;
  assign last_id_o   = last_id_q;
`endif

endmodule
